// File: rtl/cypher_feeder_if.sv
// cypher_feeder_if: feeder bus; master drives start/key/right, slave returns num/read/busy/done/matched/digits_sent/sum_mirror
interface cypher_feeder_if;
  logic start;
  logic [15:0] key;
  logic right;
  logic [3:0] num;
  logic read;
  logic busy;
  logic done;
  logic matched;
  logic [7:0] digits_sent;
  logic [7:0] sum_mirror;
  modport master (
    output start, key, right,
    input num, read, busy, done, matched, digits_sent, sum_mirror
  );
  modport slave (
    input start, key, right,
    output num, read, busy, done, matched, digits_sent, sum_mirror
  );
endinterface

// File: rtl/cypher_feeder.sv
// cypher_feeder: streams captured key nibbles as read-strobed digits until right or budget; ports i_clock, i_reset (async high), bus (cypher_feeder_if.slave)
module cypher_feeder #(
  parameter int MAX_DIGITS = 32,
  parameter int GAP = 1,
  parameter int DRAIN = 2
) (
  input logic i_clock,
  input logic i_reset,
  cypher_feeder_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SEND, HOLD, DRN, DONE} state_t;
  localparam logic [7:0] MAXD = 8'(MAX_DIGITS);
  localparam logic [7:0] GL = 8'(GAP - 1);
  localparam logic [7:0] DL = 8'(DRAIN - 1);
  localparam state_t TAIL = DRAIN > 0 ? DRN : DONE;
  state_t r_state, w_next;
  logic [15:0] r_key;
  logic [1:0] r_idx;
  logic [7:0] r_cnt, r_sent, r_sum;
  logic [3:0] r_num, w_nib;
  logic r_matched, w_active;
  assign w_nib = r_idx == 2'd0 ? r_key[15:12] :
                 r_idx == 2'd1 ? r_key[11:8] :
                 r_idx == 2'd2 ? r_key[7:4] : r_key[3:0];
  assign w_active = r_state == SEND || r_state == HOLD || r_state == DRN;
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_cnt <= '0;
    end else begin
      r_state <= w_next;
      r_cnt <= w_next == r_state ? r_cnt + 8'd1 : '0;
    end
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: w_next = bus.start ? SEND : IDLE;
      SEND: w_next = bus.right ? DONE : GAP > 0 ? HOLD : r_sent + 8'd1 < MAXD ? SEND : TAIL;
      HOLD: w_next = bus.right ? DONE : r_cnt != GL ? HOLD : r_sent < MAXD ? SEND : TAIL;
      DRN: w_next = bus.right || r_cnt == DL ? DONE : DRN;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    bus.read = r_state == SEND;
    bus.busy = r_state != IDLE;
    bus.done = r_state == DONE;
    bus.num = r_state == SEND ? w_nib : r_num;
    bus.matched = r_matched;
    bus.digits_sent = r_sent;
    bus.sum_mirror = r_sum;
  end
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_key <= '0;
      r_idx <= '0;
      r_num <= '0;
      r_sent <= '0;
      r_sum <= '0;
      r_matched <= 1'b0;
    end else begin
      if (r_state == IDLE && bus.start) begin
        r_key <= bus.key;
        r_idx <= '0;
        r_sent <= '0;
        r_sum <= '0;
        r_matched <= 1'b0;
      end
      if (r_state == SEND) begin
        r_num <= w_nib;
        r_sent <= r_sent + 8'd1;
        r_sum <= r_sum + {4'd0, w_nib};
        r_idx <= r_idx + 2'd1;
      end
      if (w_active && bus.right) r_matched <= 1'b1;
    end
  end
endmodule

// File: tb/tb_cypher_feeder.sv
// tb_cypher_feeder: four differently parameterised feeders driven by directed and random runs against a timeline model
module tb_cypher_feeder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic right = 1'b0;
  logic [15:0] key = '0;
  int sel = 0;
  int compared = 0;
  int mismatched = 0;
  int md [4] = '{6, 32, 20, 4};
  int gp [4] = '{0, 1, 1, 0};
  localparam int DR = 2;
  logic [3:0][3:0] a_num;
  logic [3:0] a_read, a_busy, a_done, a_matched;
  logic [3:0][7:0] a_sent, a_sum;
  logic [3:0] num;
  logic read, busy, done, matched;
  logic [7:0] sent, sum;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 4; g++) begin : g_dut
    cypher_feeder_if bus ();
    assign bus.start = start && sel == g;
    assign bus.key = key;
    assign bus.right = right;
    assign a_num[g] = bus.num;
    assign a_read[g] = bus.read;
    assign a_busy[g] = bus.busy;
    assign a_done[g] = bus.done;
    assign a_matched[g] = bus.matched;
    assign a_sent[g] = bus.digits_sent;
    assign a_sum[g] = bus.sum_mirror;
    cypher_feeder #(
      .MAX_DIGITS(g == 0 ? 6 : g == 1 ? 32 : g == 2 ? 20 : 4),
      .GAP(g == 0 || g == 3 ? 0 : 1),
      .DRAIN(DR)
    ) dut (
      .i_clock(clk),
      .i_reset(rst),
      .bus(bus)
    );
  end
  assign num = a_num[sel[1:0]];
  assign read = a_read[sel[1:0]];
  assign busy = a_busy[sel[1:0]];
  assign done = a_done[sel[1:0]];
  assign matched = a_matched[sel[1:0]];
  assign sent = a_sent[sel[1:0]];
  assign sum = a_sum[sel[1:0]];
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s (dut %0d): observed %h expected %h", tag, sel, obs, exp);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, ".num"}, 16'(num), 16'd0);
    chk({tag, ".read"}, 16'(read), 16'd0);
    chk({tag, ".busy"}, 16'(busy), 16'd0);
    chk({tag, ".done"}, 16'(done), 16'd0);
    chk({tag, ".matched"}, 16'(matched), 16'd0);
    chk({tag, ".digits_sent"}, 16'(sent), 16'd0);
    chk({tag, ".sum_mirror"}, 16'(sum), 16'd0);
  endtask
  // Called on a falling edge; rt/sp are run cycles (1 = first strobe cycle) where right/start pulse, 0 = never.
  task automatic run(input int s, input logic [15:0] k, input int rt, input int sp);
    int p, ta, en, cnt, sm, idx;
    logic er, mt;
    logic [3:0] nb;
    p = gp[s] + 1;
    ta = md[s] * p + DR;
    mt = rt >= 1 && rt <= ta;
    en = mt ? rt : ta;
    cnt = 0;
    sm = 0;
    sel = s;
    key = k;
    right = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int t = 1; t <= en + 1; t++) begin
      er = t <= en && (t - 1) % p == 0 && (t - 1) / p < md[s];
      chk("read", 16'(read), 16'(er));
      if (er) begin
        idx = ((t - 1) / p) % 4;
        nb = 4'(k >> (12 - 4 * idx));
        chk("num", 16'(num), 16'(nb));
        cnt++;
        sm += int'(nb);
      end
      chk("busy", 16'(busy), 16'd1);
      chk("done", 16'(done), 16'(t == en + 1));
      if (t == en + 1) begin
        chk("matched@done", 16'(matched), 16'(mt));
        chk("digits@done", 16'(sent), 16'(cnt));
        chk("sum@done", 16'(sum), 16'(sm % 256));
      end
      start = t == sp;
      right = t == rt;
      @(negedge clk);
    end
    start = 1'b0;
    right = 1'b1;
    repeat (3) begin
      chk("idle.busy", 16'(busy), 16'd0);
      chk("idle.done", 16'(done), 16'd0);
      chk("idle.matched", 16'(matched), 16'(mt));
      chk("idle.digits", 16'(sent), 16'(cnt));
      chk("idle.sum", 16'(sum), 16'(sm % 256));
      @(negedge clk);
    end
    right = 1'b0;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int s, ta, rt, sp;
    #1 rst = 1'b1;
    #2;
    for (int i = 0; i < 4; i++) begin
      sel = i;
      #1;
      chk_zero("reset");
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    sel = 1;
    key = 16'h1234;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk_zero("midrun_reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("post_reset.busy", 16'(busy), 16'd0);
      chk("post_reset.done", 16'(done), 16'd0);
    end
    run(1, 16'h1234, 0, 0);
    run(0, 16'hA5F0, 0, 0);
    run(1, 16'h1111, 6, 0);
    run(2, 16'hFFFF, 0, 0);
    run(1, 16'hBEEF, 9, 4);
    run(3, 16'h9C3E, 4, 0);
    run(0, 16'h0F0F, 0, 3);
    repeat (20) begin
      s = $urandom_range(0, 3);
      ta = md[s] * (gp[s] + 1) + DR;
      rt = $urandom_range(0, 1) != 0 ? $urandom_range(1, ta + 1) : 0;
      sp = $urandom_range(0, 1) != 0 ? $urandom_range(1, ta) : 0;
      run(s, 16'($urandom), rt, sp);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
